// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage: RV32I funct3 codes,
// FSM states, request/fault structs and the byte-enable decode.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    typedef struct packed {
        logic        rd;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic illegal;
        logic misalign;
        logic oob;
    } dmem_flt_t;

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            F3_B, F3_BU: byte_en = 4'b0001 << a;
            F3_H, F3_HU: byte_en = a[1] ? 4'b1100 : 4'b0011;
            F3_W:        byte_en = 4'b1111;
            default:     byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between execute and the data-memory stage.
interface dmem_if;
    logic        req_valid_i;
    logic        memRW_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] dataW_i;
    logic [31:0] data_o;
    logic [31:0] alu_o;
    logic        resp_valid_o;
    logic        stall_o;
    logic        misalign_o;
    logic        oob_o;
    logic        illegal_o;

    modport slave (
        input  req_valid_i, memRW_i, funct3_i, addr_i, dataW_i,
        output data_o, alu_o, resp_valid_o, stall_o, misalign_o, oob_o, illegal_o
    );

    modport master (
        output req_valid_i, memRW_i, funct3_i, addr_i, dataW_i,
        input  data_o, alu_o, resp_valid_o, stall_o, misalign_o, oob_o, illegal_o
    );
endinterface

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte-enables/data replication, load lane
// extraction with sign/zero extension, and prioritised fault decode.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  dmem_req_t   req,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata,
    output dmem_flt_t   flt
);

    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    logic       illegal, mis, oob_raw;
    logic [7:0] lane_b;
    logic [15:0] lane_h;

    always_comb begin
        if (req.rd)
            illegal = !(req.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        else
            illegal = !(req.funct3 inside {F3_B, F3_H, F3_W});

        case (req.funct3[1:0])
            2'b01:   mis = req.addr[0];
            2'b10:   mis = |req.addr[1:0];
            default: mis = 1'b0;
        endcase

        oob_raw = {2'b00, req.addr[31:2]} >= DEPTH_W32;

        // Only the highest-priority fault is reported.
        flt.illegal  = illegal;
        flt.misalign = !illegal && mis;
        flt.oob      = !illegal && !mis && oob_raw;
    end

    // Store data is replicated across lanes; the byte-enable picks the live ones.
    always_comb begin
        be = byte_en(req.funct3, req.addr[1:0]);
        case (req.funct3[1:0])
            2'b00:   wdata = {4{req.wdata[7:0]}};
            2'b01:   wdata = {2{req.wdata[15:0]}};
            default: wdata = req.wdata;
        endcase
    end

    always_comb begin
        lane_b = rword[8*req.addr[1:0] +: 8];
        lane_h = req.addr[1] ? rword[31:16] : rword[15:0];
        case (req.funct3)
            F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
            F3_BU:   rdata = {24'h0, lane_b};
            F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
            F3_HU:   rdata = {16'h0, lane_h};
            F3_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage between execute and writeback: word array, wait-state
// FSM and registered load/ALU/fault outputs towards writeback.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic [31:0] data_q, data_d;
    logic [31:0] alu_q, alu_d;
    logic        resp_q, resp_d;
    dmem_flt_t   flt_q, flt_d;

    logic [3:0][7:0] mem_q [DEPTH_WORDS];

    dmem_req_t   in_req, ex_req;
    logic        accept, ex_go, we;
    logic [AW-1:0] widx;
    logic [31:0] rword, wsh, rdata;
    logic [3:0]  be;
    dmem_flt_t   flt;

    assign in_req = '{rd: bus.memRW_i, funct3: bus.funct3_i,
                      addr: bus.addr_i, wdata: bus.dataW_i};
    assign accept = (state_q == IDLE) && bus.req_valid_i;

    // Without wait states the incoming request executes at its accept edge.
    assign ex_req = (WAIT_CYCLES == 0) ? in_req : req_q;
    assign ex_go  = (WAIT_CYCLES == 0) ? accept
                                       : ((state_q == WAIT) && (cnt_q == 4'd1));

    assign widx  = ex_req.addr[AW+1:2];
    assign rword = mem_q[widx];

    dmem_align #(.DEPTH_WORDS(DEPTH_WORDS)) u_align (
        .req   (ex_req),
        .rword (rword),
        .be    (be),
        .wdata (wsh),
        .rdata (rdata),
        .flt   (flt)
    );

    // Gating on rst keeps a store presented during reset from committing.
    assign we = ex_go && rst && !ex_req.rd && !(|flt);

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem_q[widx][l] <= wsh[8*l +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        alu_d   = alu_q;
        flt_d   = flt_q;
        resp_d  = 1'b0;

        if (accept) req_d = in_req;

        case (state_q)
            IDLE: begin
                if (accept && (WC != 4'd0)) begin
                    state_d = WAIT;
                    cnt_d   = WC;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ex_go) begin
            resp_d = 1'b1;
            alu_d  = ex_req.addr;
            flt_d  = flt;
            data_d = (ex_req.rd && !(|flt)) ? rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            data_q  <= 32'h0;
            alu_q   <= 32'h0;
            resp_q  <= 1'b0;
            flt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            alu_q   <= alu_d;
            resp_q  <= resp_d;
            flt_q   <= flt_d;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.alu_o        = alu_q;
    assign bus.resp_valid_o = resp_q;
    assign bus.stall_o      = (state_q == WAIT);
    assign bus.misalign_o   = flt_q.misalign;
    assign bus.oob_o        = flt_q.oob;
    assign bus.illegal_o    = flt_q.illegal;

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Parametrised data-memory stage for the RISC-V core; sits between execute and writeback.
- Supports RV32I byte/half/word loads and stores with sign/zero extension.
- Adds misalignment, out-of-range and illegal-funct3 detection, plus optional wait states via a stall output.
- Registers the load result and the ALU/address pass-through towards writeback.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, >=2)
- WAIT_CYCLES, 0, extra cycles each access takes (0..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present this cycle
- memRW_i  in  1  1 = load, 0 = store
- funct3_i  in  3  RV32I width/sign code
- addr_i  in  32  byte address (ALU result)
- dataW_i  in  32  store data
- data_o  out  32  registered load result
- alu_o  out  32  registered copy of the accepted addr_i
- resp_valid_o  out  1  one-cycle pulse: data_o/alu_o/flags valid
- stall_o  out  1  high while busy; upstream holds its request
- misalign_o  out  1  fault flag, valid with resp_valid_o
- oob_o  out  1  fault flag, valid with resp_valid_o
- illegal_o  out  1  fault flag, valid with resp_valid_o

Behaviour:
- Reset (rst=0, async): data_o=0, alu_o=0, resp_valid_o=0, all flags 0, state IDLE, counter 0.
  - The array is not reset.
  - A pending access is abandoned; an uncommitted store never writes.
- States:
  - IDLE: a request with req_valid_i=1 is accepted and latched at the clock edge.
    - WAIT_CYCLES=0: the access executes at that same edge and the state stays IDLE.
    - WAIT_CYCLES>0: go to WAIT and load the counter with WAIT_CYCLES.
  - WAIT: stall_o=1 and new requests are ignored; the counter decrements each edge.
    - At the edge where counter==1, the access executes and the state returns to IDLE.
- Timing:
  - Request in cycle 0; stall_o high in cycles 1..N; resp_valid_o=1 in cycle N+1 only (N=WAIT_CYCLES).
  - A new request can be accepted in cycle N+1.
  - With N=0, back-to-back accesses run one per cycle.
- stall_o is a decode of state==WAIT; it never depends on req_valid_i.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Fault checks, in priority order; a faulting access never writes, and data_o=0 on a faulting load:
  - illegal: load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010}.
  - misalign: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - oob: addr[31:2] >= DEPTH_WORDS.
  - Only the highest-priority fault flag is set.
- Store byte lanes:
  - SB (000) writes lane addr[1:0] with dataW[7:0].
  - SH (001) writes lanes {addr[1],0} and {addr[1],1} with dataW[15:0].
  - SW (010) writes all four lanes.
  - Unwritten lanes keep their value.
- Load extraction:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - Lane selection is the same as for stores.
- Store response: resp_valid_o pulses; data_o=0; alu_o=addr.
- Between responses: data_o, alu_o and flags hold their last values; resp_valid_o=0.
- Read after write: a load accepted after a store's response returns the stored data. There are no simultaneous accesses, so no forwarding is required.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum {IDLE, WAIT};
  - a function computing the 4-bit byte-enable from funct3 and addr[1:0].
- One combinational sub-module, dmem_align:
  - store side: byte-enable and lane-shifted write data;
  - load side: lane select plus extension;
  - fault decode.
- The array, FSM, counter and output registers stay in dmem_stage.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 (N=0) -> resp_valid_o the cycle after each request; data_o=0xDEADBEEF, alu_o=0x10, all flags 0.
- SB dataW=0x80 @0x13, then LB/LBU/LW @0x13/0x13/0x10 -> 0xFFFFFF80, 0x00000080, 0x80ADBEEF.
- SH @0x11, then LW @0x12 -> misalign_o=1 for each; a following LW @0x10 still reads 0x80ADBEEF.
- DEPTH_WORDS=256: LW @0x400 -> oob_o=1, data_o=0. Load funct3=011 -> illegal_o=1, misalign_o=0, oob_o=0.
- WAIT_CYCLES=2, LW in cycle 0 with a second request held by upstream -> stall_o=1 in cycles 1–2, resp_valid_o in cycle 3, second request accepted in cycle 3, its response in cycle 6.
- WAIT_CYCLES=2: SW 0x12345678 @0x20 over old 0x0 value, rst=0 in cycle 1 -> all outputs 0 immediately; after release, LW @0x20 returns 0x0.
